// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and forwarding controller for the in-order MIPS pipeline. It sits
//   beside decode and records every in-flight register write in a STAGES-deep
//   scoreboard shift register (entry 0 = EX). From that record it produces the
//   PC / IF_ID write enables, the IF_ID flush, the ID_EX bubble and registered
//   forwarding selects for the EX operand muxes.
//
//   Build option HAZARD_FWD_EN:
//     defined   - forwarding; only a load that is still too young stalls.
//     undefined - full interlock; any pending write to a source stalls and
//                 the forwarding selects are tied to 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   id_valid            decode stage holds a real instruction
//   id_rs / id_rt       source addresses, id_use_rs / id_use_rt qualify them
//   id_rd               destination (already reg_dst-muxed)
//   id_reg_write        instruction writes the register file
//   id_mem_read         instruction is a load
//   branch_taken        EX resolved a taken branch this cycle
//   ext_stall           global freeze
//   pc_write_en         PC may update
//   if_id_write_en      IF_ID may capture
//   if_id_flush         IF_ID loads a NOP
//   id_ex_bubble        ID_EX loads a NOP
//   fwd_a_sel/fwd_b_sel EX operand sources (0 = register file, k+1 = entry k)
//   stall_count         saturating count of hazard-stall cycles
module pipeline_hazard_ctrl #(
  parameter int STAGES   = 3,
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  parameter int SEL_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              branch_taken,
  input  logic              ext_stall,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic [SEL_W-1:0]  fwd_a_sel,
  output logic [SEL_W-1:0]  fwd_b_sel,
  output logic [CNT_W-1:0]  stall_count
);

  // Scoreboard: bit/slot k describes the write held by post-decode stage k.
  logic [STAGES-1:0]             r_v;
  logic [STAGES-1:0][REG_AW-1:0] r_rd;
  logic [CNT_W-1:0]              r_stall_cnt;

  logic [STAGES-1:0] w_match_a;
  logic [STAGES-1:0] w_match_b;
  logic              w_hz;
  logic              w_accept;
  logic              w_ins_v;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_match
      assign w_match_a[gi] = id_use_rs & r_v[gi] & (r_rd[gi] == id_rs) & (id_rs != '0);
      assign w_match_b[gi] = id_use_rt & r_v[gi] & (r_rd[gi] == id_rt) & (id_rt != '0);
    end
  endgenerate

`ifdef HAZARD_FWD_EN
  logic [STAGES-1:0] r_ld;
  logic [STAGES-1:0] w_early;
  logic [SEL_W-1:0]  w_sel_a;
  logic [SEL_W-1:0]  w_sel_b;
  logic [SEL_W-1:0]  r_fwd_a;
  logic [SEL_W-1:0]  r_fwd_b;

  // Entries whose load data has not yet come back from memory.
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_early
      assign w_early[gi] = (gi < LOAD_LAT);
    end
  endgenerate

  assign w_hz = id_valid & (|((w_match_a | w_match_b) & r_ld & w_early));

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    w_sel_a = '0;
    w_sel_b = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      if (w_match_a[k]) w_sel_a = SEL_W'(k + 1);
      if (w_match_b[k]) w_sel_b = SEL_W'(k + 1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ld    <= '0;
      r_fwd_a <= '0;
      r_fwd_b <= '0;
    end else if (!ext_stall) begin
      r_ld    <= {r_ld[STAGES-2:0], id_mem_read};
      r_fwd_a <= w_accept ? w_sel_a : '0;
      r_fwd_b <= w_accept ? w_sel_b : '0;
    end
  end

  assign fwd_a_sel = r_fwd_a;
  assign fwd_b_sel = r_fwd_b;
`else
  logic w_unused;

  // Without forwarding any pending write to a source must drain first.
  assign w_hz      = id_valid & (|(w_match_a | w_match_b));
  assign fwd_a_sel = '0;
  assign fwd_b_sel = '0;
  assign w_unused  = id_mem_read;
`endif

  // A taken branch squashes decode, so its hazard is irrelevant.
  assign w_accept = ~branch_taken & ~w_hz;
  assign w_ins_v  = w_accept & id_valid & id_reg_write & (id_rd != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v         <= '0;
      r_rd        <= '0;
      r_stall_cnt <= '0;
    end else if (!ext_stall) begin
      r_v  <= {r_v[STAGES-2:0], w_ins_v};
      r_rd <= {r_rd[STAGES-2:0], id_rd};
      if (!branch_taken && w_hz && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign stall_count = r_stall_cnt;

  always_comb begin
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    if (!reset && !ext_stall) begin
      if (branch_taken) begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
        if_id_flush    = 1'b1;
        id_ex_bubble   = 1'b1;
      end else if (w_hz) begin
        id_ex_bubble   = 1'b1;
      end else begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios followed by
// randomized traffic, every cycle compared against an instruction-level model
// of the in-flight writes.
module tb_pipeline_hazard_ctrl;
  localparam int STAGES   = 3;
  localparam int REG_AW   = 5;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 16;
  localparam int SEL_W    = 2;
`ifdef HAZARD_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_AW-1:0] id_rs, id_rt, id_rd;
  logic              id_use_rs, id_use_rt, id_reg_write, id_mem_read;
  logic              branch_taken, ext_stall;
  logic              pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble;
  logic [SEL_W-1:0]  fwd_a_sel, fwd_b_sel;
  logic [CNT_W-1:0]  stall_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(
    .STAGES(STAGES), .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .CNT_W(CNT_W), .SEL_W(SEL_W)
  ) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .branch_taken(branch_taken), .ext_stall(ext_stall),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel), .stall_count(stall_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Instructions that have left decode and still owe a register write,
  // index 0 = the one currently in EX.
  typedef struct { bit v; int rd; bit ld; } flight_t;
  flight_t m_fl[STAGES];
  int      m_fa, m_fb;
  longint  m_cnt;

  // observed outputs of the most recent cycle
  bit obs_pc, obs_ifid, obs_flush, obs_bub;
  int obs_fa, obs_fb, obs_cnt;

  function automatic void model_clear();
    for (int k = 0; k < STAGES; k++) m_fl[k] = '{v: 1'b0, rd: 0, ld: 1'b0};
    m_fa  = 0;
    m_fb  = 0;
    m_cnt = 0;
  endfunction

  // distance to the nearest older instruction writing src, -1 if none
  function automatic int producer(int src, bit used);
    if (!used || src == 0) return -1;
    for (int k = 0; k < STAGES; k++)
      if (m_fl[k].v && m_fl[k].rd == src) return k;
    return -1;
  endfunction

  function automatic bit model_hz();
    if (!id_valid) return 1'b0;
`ifdef HAZARD_FWD_EN
    // a load's value is usable only once it is LOAD_LAT stages past decode
    for (int k = 0; k < LOAD_LAT; k++) begin
      if (m_fl[k].v && m_fl[k].ld &&
          ((id_use_rs && id_rs != 0 && m_fl[k].rd == int'(id_rs)) ||
           (id_use_rt && id_rt != 0 && m_fl[k].rd == int'(id_rt))))
        return 1'b1;
    end
    return 1'b0;
`else
    return (producer(int'(id_rs), id_use_rs) >= 0) || (producer(int'(id_rt), id_use_rt) >= 0);
`endif
  endfunction

  function automatic void model_clock(bit hz);
    int  da, db;
    bit  take;
    if (reset) begin
      model_clear();
      return;
    end
    if (ext_stall) return;
    da   = producer(int'(id_rs), id_use_rs);
    db   = producer(int'(id_rt), id_use_rt);
    take = !branch_taken && !hz;
    for (int k = STAGES - 1; k > 0; k--) m_fl[k] = m_fl[k-1];
    m_fl[0] = '{v: take && id_valid && id_reg_write && id_rd != 0, rd: int'(id_rd), ld: id_mem_read};
    m_fa = (FWD && take && da >= 0) ? da + 1 : 0;
    m_fb = (FWD && take && db >= 0) ? db + 1 : 0;
    if (!branch_taken && hz && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
  endfunction

  // One clock: check outputs against the model, then advance both.
  task automatic cycle(string tag);
    bit hz, e_pc, e_ifid, e_fl, e_bub;
    #1;
    if (reset) model_clear();
    hz     = model_hz();
    e_pc   = 0; e_ifid = 0; e_fl = 0; e_bub = 0;
    if (!reset && !ext_stall) begin
      if (branch_taken) begin
        e_pc = 1; e_ifid = 1; e_fl = 1; e_bub = 1;
      end else if (hz) begin
        e_bub = 1;
      end else begin
        e_pc = 1; e_ifid = 1;
      end
    end
    obs_pc = pc_write_en; obs_ifid = if_id_write_en; obs_flush = if_id_flush;
    obs_bub = id_ex_bubble; obs_fa = int'(fwd_a_sel); obs_fb = int'(fwd_b_sel);
    obs_cnt = int'(stall_count);
    chk({tag, ".pc_we"},  pc_write_en,    e_pc);
    chk({tag, ".ifid_we"}, if_id_write_en, e_ifid);
    chk({tag, ".flush"},  if_id_flush,    e_fl);
    chk({tag, ".bubble"}, id_ex_bubble,   e_bub);
    chk({tag, ".fwd_a"},  fwd_a_sel,      m_fa);
    chk({tag, ".fwd_b"},  fwd_b_sel,      m_fb);
    chk({tag, ".count"},  stall_count,    m_cnt[31:0]);
    $display("[TB] %s rst=%b ext=%b br=%b v=%b rs=%0d rt=%0d rd=%0d ld=%b | pc=%b bub=%b fl=%b fa=%0d fb=%0d cnt=%0d",
             tag, reset, ext_stall, branch_taken, id_valid, id_rs, id_rt, id_rd, id_mem_read,
             pc_write_en, id_ex_bubble, if_id_flush, fwd_a_sel, fwd_b_sel, stall_count);
    @(posedge clk);
    model_clock(hz);
    @(negedge clk);
  endtask

  task automatic set_ins(bit v, int rs, int rt, bit urs, bit urt, int rd, bit rw, bit ld);
    id_valid = v; id_rs = REG_AW'(rs); id_rt = REG_AW'(rt);
    id_use_rs = urs; id_use_rt = urt; id_rd = REG_AW'(rd);
    id_reg_write = rw; id_mem_read = ld;
  endtask

  task automatic nop();
    set_ins(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Hold the current decode instruction until the controller lets it go.
  task automatic issue(string tag, output int stalls);
    stalls = 0;
    for (int i = 0; i < 12; i++) begin
      cycle(tag);
      if (obs_pc) return;
      stalls++;
    end
    chk({tag, ".accepted"}, obs_pc, 1);
  endtask

  task automatic drain();
    nop();
    for (int i = 0; i < STAGES; i++) cycle("drain");
  endtask

  int s, c0;

  initial begin
    model_clear();
    reset = 1; branch_taken = 0; ext_stall = 0;
    nop();
    @(negedge clk);
    cycle("rst");
    reset = 0;
    cycle("idle");

    // add $3,$1,$2 ; sub $4,$3,$5
    set_ins(1, 1, 2, 1, 1, 3, 1, 0); issue("fwd1.add", s);
    set_ins(1, 3, 5, 1, 1, 4, 1, 0); issue("fwd1.sub", s);
    chk("fwd1.stalls", s, FWD ? 0 : 3);
    nop(); cycle("fwd1.ex");
    chk("fwd1.sel_a", obs_fa, FWD ? 1 : 0);
    drain();

    // add $3 ; nop ; sub $4,$3,$5
    set_ins(1, 1, 2, 1, 1, 3, 1, 0); issue("fwd2.add", s);
    nop(); issue("fwd2.nop", s);
    set_ins(1, 3, 5, 1, 1, 4, 1, 0); issue("fwd2.sub", s);
    chk("fwd2.stalls", s, FWD ? 0 : 2);
    nop(); cycle("fwd2.ex");
    chk("fwd2.sel_a", obs_fa, FWD ? 2 : 0);
    drain();

    // lw $2,0($1) ; add $6,$2,$2
    c0 = obs_cnt;
    set_ins(1, 1, 0, 1, 0, 2, 1, 1); issue("lu.lw", s);
    set_ins(1, 2, 2, 1, 1, 6, 1, 0); issue("lu.add", s);
    chk("lu.stalls", s, FWD ? 1 : 3);
    nop(); cycle("lu.ex");
    chk("lu.sel_a", obs_fa, FWD ? 2 : 0);
    chk("lu.sel_b", obs_fb, FWD ? 2 : 0);
    chk("lu.count_delta", obs_cnt - c0, FWD ? 1 : 3);
    drain();

    // load-use coinciding with a taken branch
    c0 = obs_cnt;
    set_ins(1, 1, 0, 1, 0, 2, 1, 1); issue("lubr.lw", s);
    set_ins(1, 2, 2, 1, 1, 6, 1, 0); branch_taken = 1;
    cycle("lubr.br");
    chk("lubr.flush", obs_flush, 1);
    chk("lubr.bubble", obs_bub, 1);
    chk("lubr.pc_we", obs_pc, 1);
    branch_taken = 0; nop(); cycle("lubr.after");
    chk("lubr.count", obs_cnt, c0);
    drain();

    // ext_stall held during a load-use
    c0 = obs_cnt;
    set_ins(1, 1, 0, 1, 0, 2, 1, 1); issue("lux.lw", s);
    set_ins(1, 2, 2, 1, 1, 6, 1, 0); ext_stall = 1;
    for (int i = 0; i < 4; i++) begin
      cycle("lux.frz");
      chk("lux.frz_pc", obs_pc, 0);
      chk("lux.frz_bub", obs_bub, 0);
    end
    chk("lux.frz_count", obs_cnt, c0);
    ext_stall = 0; issue("lux.add", s);
    chk("lux.stalls", s, FWD ? 1 : 3);
    nop(); cycle("lux.ex");
    chk("lux.count_delta", obs_cnt - c0, FWD ? 1 : 3);
    drain();

    // add $3 ; or $7,$3,$0
    c0 = obs_cnt;
    set_ins(1, 1, 2, 1, 1, 3, 1, 0); issue("il.add", s);
    set_ins(1, 3, 0, 1, 1, 7, 1, 0); issue("il.or", s);
    chk("il.stalls", s, FWD ? 0 : 3);
    nop(); cycle("il.ex");
    chk("il.sel_a", obs_fa, FWD ? 1 : 0);
    chk("il.sel_b", obs_fb, 0);
    chk("il.count_delta", obs_cnt - c0, FWD ? 0 : 3);

    // reset with writes in flight
    set_ins(1, 1, 2, 1, 1, 3, 1, 1); issue("mr.lw", s);
    set_ins(1, 5, 6, 1, 1, 4, 1, 0); issue("mr.add", s);
    set_ins(1, 3, 4, 1, 1, 8, 1, 0); reset = 1;
    cycle("mr.rst");
    chk("mr.rst_pc", obs_pc, 0);
    chk("mr.rst_cnt", obs_cnt, 0);
    reset = 0;
    cycle("mr.rel");
    chk("mr.rel_pc", obs_pc, 1);
    nop(); cycle("mr.ex");
    chk("mr.rel_fwd_a", obs_fa, 0);

    // randomized traffic over a small register set to provoke matches
    for (int i = 0; i < 600; i++) begin
      set_ins($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      ext_stall    = ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 99) == 0);
      cycle("rnd");
    end
    reset = 0; branch_taken = 0; ext_stall = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the in-order MIPS pipeline.
- Sits beside decode and tracks every in-flight register write in a STAGES-deep scoreboard shift register (EX, DM, WB for the default).
- Generates PC/IF_ID write enables, IF_ID flush and ID_EX bubble.
- Provides registered forwarding selects for the EX operand muxes.
- Successor to fixed, hazard-free stage wiring: supports configurable depth, load latency, branch flush and a global freeze.

Parameters:
- STAGES, 3, number of post-decode stages that hold a pending register write (entry 0 = EX).
- REG_AW, 5, register address width.
- LOAD_LAT, 1, number of leading entries in which a load's data is not yet forwardable (1..STAGES-1).
- CNT_W, 16, width of the stall-cycle counter.
- SEL_W, 2, forwarding select width; must satisfy 2^SEL_W > STAGES.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs  in  REG_AW  source A address.
- id_rt  in  REG_AW  source B address.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_rd  in  REG_AW  destination address, already reg_dst-muxed.
- id_reg_write  in  1  instruction writes the register file.
- id_mem_read  in  1  instruction is a load.
- branch_taken  in  1  EX resolved a taken branch this cycle.
- ext_stall  in  1  global freeze (e.g. data memory busy).
- pc_write_en  out  1  PC may update.
- if_id_write_en  out  1  IF_ID may capture.
- if_id_flush  out  1  IF_ID loads a NOP.
- id_ex_bubble  out  1  ID_EX loads a NOP.
- fwd_a_sel  out  SEL_W  EX operand A source, registered.
- fwd_b_sel  out  SEL_W  EX operand B source, registered.
- stall_count  out  CNT_W  saturating count of hazard-stall cycles.

Behaviour:
- Scoreboard: entries 0..STAGES-1, each {v, rd, ld}.
- A source matches entry k when: the use bit is set, v=1, rd equals the source address, and the source address is nonzero.
- Youngest (lowest k) match wins.
- hz (hazard) = id_valid & either source matches an entry k < LOAD_LAT with ld=1.
- Priority each cycle: reset > ext_stall > branch_taken > hz > normal.
- reset (asynchronous): all v=0, fwd sels=0, stall_count=0.
- While reset is asserted: pc_write_en=0, if_id_write_en=0, if_id_flush=0, id_ex_bubble=0.
- ext_stall=1: scoreboard, fwd sels and counter hold. pc_write_en=0, if_id_write_en=0, flush=0, bubble=0.
- branch_taken=1:
  - if_id_flush=1, id_ex_bubble=1, pc_write_en=1, if_id_write_en=1.
  - Entry 0 loads v=0; other entries shift (k takes k-1); fwd sels load 0.
  - hz is ignored and the counter does not increment.
- hz=1:
  - pc_write_en=0, if_id_write_en=0, id_ex_bubble=1.
  - Entry 0 loads v=0; others shift; fwd sels load 0.
  - stall_count increments, saturating at all-ones.
- Normal:
  - Enables are 1; flush and bubble are 0.
  - Entry 0 loads v = id_valid & id_reg_write & (id_rd != 0), rd = id_rd, ld = id_mem_read.
  - Others shift.
  - fwd_x_sel loads k+1 for the youngest matching entry k, else 0.
  - Encoding: 1 = EX/DM result, 2 = DM/WB result, STAGES = write-back data.
- Entry STAGES-1 is discarded on shift. The write it represents has retired to the register file.
- Register address 0 never creates a hazard or forward.
- A hazard lasts exactly LOAD_LAT - k cycles for a load match in entry k.

Optional Feature:
- Macro HAZARD_FWD_EN.
- Defined: behaviour as above.
- Undefined: full interlock.
  - hz = id_valid & any source match in any entry, regardless of ld.
  - fwd_a_sel and fwd_b_sel are constant 0.
  - Same priority order and counter rules as when defined.

Test Plan:
- Reset mid-run: assert reset with entries valid → all outputs 0 immediately; after release, pc_write_en=1, fwd sels 0.
- Forwarding, add $3 followed by sub $4,$3,$5 → no stall; fwd_a_sel=1 in the sub's EX cycle. With one NOP between them → fwd_a_sel=2.
- Load-use, lw $2 followed by add $6,$2,$2 → exactly 1 stall cycle (pc_write_en=0, id_ex_bubble=1); then fwd_a_sel=fwd_b_sel=2; stall_count=1.
- Load-use coinciding with branch_taken=1 → flush and bubble asserted, pc_write_en=1, no stall, stall_count unchanged.
- ext_stall held 4 cycles during load-use → all state frozen; on release, the single stall completes; stall_count=1.
- HAZARD_FWD_EN undefined, add $3 followed by or $7,$3,$0 → 3 stall cycles (STAGES=3), fwd sels 0, stall_count=3.
